// File: rtl/mem_req_bridge.sv
// mem_req_bridge: turns the level-held write/read requests of mem_test_sm into
// single Avalon-MM master transactions, and returns a one-cycle confirm plus
// readback data. A watchdog aborts stalled transactions so the requester never
// hangs. txn_count tallies completed transactions for debug.
//
// state   | meaning
// --------+------------------------------------------------------------------
// IDLE    | waiting for a request; requester inputs are sampled only here
// WR_CMD  | avm_write asserted, held until the slave drops waitrequest
// RD_CMD  | avm_read asserted, held until the slave drops waitrequest
// RD_DATA | read accepted, waiting for readdatavalid
// CONFIRM | one-cycle sm_confirm pulse
// HOLDOFF | one dead cycle so a still-high request is not reissued at once
module mem_req_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int WORD_WIDTH     = 32,
  parameter int ADDR_SHIFT     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sm_write,
  input  logic                    sm_read,
  input  logic [ADDR_WIDTH-1:0]   sm_address,
  input  logic [WORD_WIDTH-1:0]   sm_wdata,
  output logic                    sm_confirm,
  output logic [WORD_WIDTH-1:0]   sm_rdata,
  output logic [ADDR_WIDTH-1:0]   avm_address,
  output logic                    avm_write,
  output logic                    avm_read,
  output logic [WORD_WIDTH-1:0]   avm_writedata,
  output logic [WORD_WIDTH/8-1:0] avm_byteenable,
  input  logic                    avm_waitrequest,
  input  logic [WORD_WIDTH-1:0]   avm_readdata,
  input  logic                    avm_readdatavalid,
  output logic                    busy,
  output logic                    timeout_err,
  output logic [31:0]             txn_count
);

  localparam int BE_WIDTH = WORD_WIDTH / 8;
  localparam int WD_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Loaded on entry so the count hits zero on the TIMEOUT_CYCLES-th active cycle.
  localparam logic [WD_WIDTH-1:0] WD_LOAD = WD_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_CMD  = 3'd1,
    RD_CMD  = 3'd2,
    RD_DATA = 3'd3,
    CONFIRM = 3'd4,
    HOLDOFF = 3'd5
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [WD_WIDTH-1:0] wd_cnt;
  logic                wd_tc;
  logic                wd_active;
  logic                abort;
  logic                start;

  assign wd_tc     = (wd_cnt == '0);
  assign wd_active = (state == WR_CMD) || (state == RD_CMD) || (state == RD_DATA);
  assign start     = (state == IDLE) && (state_nxt != IDLE);
  assign busy      = (state != IDLE);

  // Next-state decode. A write accepted, or read data arriving, on the
  // terminal-count cycle still counts as a normal completion.
  always_comb begin
    state_nxt = state;
    abort     = 1'b0;
    unique case (state)
      IDLE: begin
        if (sm_write)     state_nxt = WR_CMD;
        else if (sm_read) state_nxt = RD_CMD;
      end
      WR_CMD: begin
        if (!avm_waitrequest) begin
          state_nxt = CONFIRM;
        end else if (wd_tc) begin
          state_nxt = CONFIRM;
          abort     = 1'b1;
        end
      end
      RD_CMD: begin
        if (wd_tc) begin
          state_nxt = CONFIRM;
          abort     = 1'b1;
        end else if (!avm_waitrequest) begin
          state_nxt = RD_DATA;
        end
      end
      RD_DATA: begin
        if (avm_readdatavalid) begin
          state_nxt = CONFIRM;
        end else if (wd_tc) begin
          state_nxt = CONFIRM;
          abort     = 1'b1;
        end
      end
      CONFIRM: state_nxt = HOLDOFF;
      HOLDOFF: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Avalon command outputs, registered from the next state so they never glitch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      avm_write      <= 1'b0;
      avm_read       <= 1'b0;
      avm_byteenable <= '0;
      avm_address    <= '0;
      avm_writedata  <= '0;
    end else begin
      avm_write      <= (state_nxt == WR_CMD);
      avm_read       <= (state_nxt == RD_CMD);
      avm_byteenable <= {BE_WIDTH{(state_nxt == WR_CMD) || (state_nxt == RD_CMD)}};
      if (start) begin
        avm_address <= sm_address << ADDR_SHIFT;
        if (sm_write) avm_writedata <= sm_wdata;
      end
    end
  end

  // Watchdog down-counter: reloaded on command entry, counts while active.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 wd_cnt <= '0;
    else if (start)             wd_cnt <= WD_LOAD;
    else if (wd_active && !wd_tc) wd_cnt <= wd_cnt - WD_WIDTH'(1);
  end

  // Requester-facing results: confirm pulse, readback, sticky error, counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sm_confirm  <= 1'b0;
      sm_rdata    <= '0;
      timeout_err <= 1'b0;
      txn_count   <= '0;
    end else begin
      sm_confirm <= (state_nxt == CONFIRM);
      if (state_nxt == CONFIRM) txn_count <= txn_count + 32'd1;
      if ((state == RD_DATA) && avm_readdatavalid) sm_rdata <= avm_readdata;
      else if (abort && (state != WR_CMD))          sm_rdata <= '0;
      if (abort) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_req_bridge.sv
// Directed and randomized checks of mem_req_bridge against a transaction-level
// model: each transaction's confirm cycle, command length, readback value and
// counters are predicted from stall/latency arithmetic and the timeout limit.
module tb_mem_req_bridge;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sm_write = 1'b0;
  logic        sm_read = 1'b0;
  logic [31:0] sm_address = '0;
  logic [31:0] sm_wdata = '0;
  logic        sm_confirm;
  logic [31:0] sm_rdata;
  logic [31:0] avm_address;
  logic        avm_write;
  logic        avm_read;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
  logic        busy;
  logic        timeout_err;
  logic [31:0] txn_count;

  mem_req_bridge #(
    .ADDR_WIDTH(32), .WORD_WIDTH(32), .ADDR_SHIFT(2), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .sm_write(sm_write), .sm_read(sm_read), .sm_address(sm_address), .sm_wdata(sm_wdata),
    .sm_confirm(sm_confirm), .sm_rdata(sm_rdata),
    .avm_address(avm_address), .avm_write(avm_write), .avm_read(avm_read),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .busy(busy), .timeout_err(timeout_err), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [31:0] mdl_count = '0;
  logic        mdl_terr = 1'b0;
  logic [31:0] mdl_rdata = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one transaction starting at a negedge with the bridge idle; ends two
  // cycles after confirm (bridge idle again). Slave behaviour: waitrequest
  // high for nwait command cycles, readdatavalid lat cycles after acceptance.
  task automatic run_txn(input string tag, input bit req_w, input bit req_r,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int nwait, input int lat, input logic [31:0] rdata_in,
                         input bit early, input bit hold);
    bit          is_wr = req_w;
    int          cmd_len = nwait + 1;
    bit          to;
    int          exp_conf;
    int          exp_cmd;
    logic [31:0] exp_addr = addr << 2;
    int          wr_cyc = 0;
    int          rd_cyc = 0;
    int          bad = 0;
    int          stall_left = nwait;
    int          acc = -1;
    int          conf = 0;
    int          extra = 0;
    logic [1:0]  busy_after;

    if (is_wr) begin
      to       = cmd_len > TO;
      exp_conf = to ? TO + 1 : cmd_len + 1;
    end else begin
      to       = cmd_len + lat > TO;
      exp_conf = to ? TO + 1 : cmd_len + lat + 1;
    end
    exp_cmd = (cmd_len > TO) ? TO : cmd_len;

    sm_write = req_w; sm_read = req_r; sm_address = addr; sm_wdata = wdata;
    for (int cyc = 1; cyc <= TO + 6 && conf == 0; cyc++) begin
      @(negedge clk);
      avm_readdatavalid = 1'b0;
      avm_readdata      = '0;
      if (avm_write || avm_read) begin
        if (avm_write) wr_cyc++;
        if (avm_read)  rd_cyc++;
        if (avm_address !== exp_addr || avm_byteenable !== 4'hf ||
            (avm_write && avm_writedata !== wdata)) bad++;
        avm_waitrequest = (stall_left > 0);
        if (stall_left > 0) stall_left--;
        if (!avm_waitrequest && avm_read) begin
          acc = cyc;
          if (early) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = ~rdata_in;
          end
        end
      end else begin
        avm_waitrequest = 1'b0;
        if (acc > 0 && cyc == acc + lat) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = rdata_in;
        end
      end
      if (sm_confirm) conf = cyc;
    end
    avm_readdatavalid = 1'b0;
    avm_waitrequest   = 1'b0;
    if (!hold) begin
      sm_write = 1'b0;
      sm_read  = 1'b0;
    end

    mdl_count = mdl_count + 32'd1;
    if (to) mdl_terr = 1'b1;
    if (!is_wr) mdl_rdata = to ? 32'h0 : rdata_in;

    check({tag, ".conf_cycle"}, conf, exp_conf);
    check({tag, ".write_cycles"}, wr_cyc, is_wr ? exp_cmd : 0);
    check({tag, ".read_cycles"}, rd_cyc, is_wr ? 0 : exp_cmd);
    check({tag, ".cmd_stable"}, bad, 0);
    check({tag, ".rdata"}, sm_rdata, mdl_rdata);
    check({tag, ".txn_count"}, txn_count, mdl_count);
    check({tag, ".timeout_err"}, timeout_err, mdl_terr);

    @(negedge clk);
    busy_after[1] = busy;
    if (sm_confirm || avm_write || avm_read) extra++;
    @(negedge clk);
    busy_after[0] = busy;
    if (sm_confirm || avm_write || avm_read) extra++;
    check({tag, ".holdoff_quiet"}, extra, 0);
    check({tag, ".busy_after"}, busy_after, 2'b10);
  endtask

  initial begin
    int          nw;
    int          s;
    logic [31:0] d;
    logic [31:0] a;
    int          rd_seen;

    // Reset state.
    #3 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset.outputs_zero",
          |{sm_confirm, sm_rdata, avm_address, avm_write, avm_read, avm_writedata,
            avm_byteenable, busy, timeout_err, txn_count}, 1'b0);
    reset = 1'b1;
    @(negedge clk);

    // Write, no stall, with the literal byte address from the plan.
    run_txn("wr_nostall", 1, 0, 32'h000a_aaaa, 32'hffff_ffff, 0, 0, '0, 0, 0);
    check("wr_nostall.avm_address", avm_address, 32'h002a_aaa8);

    // Read with 3 stall cycles, data 5 cycles after acceptance, plus an
    // illegal readdatavalid on the acceptance cycle that must be ignored.
    run_txn("rd_stall", 0, 1, 32'h0000_1234, '0, 3, 5, 32'hffff_feff, 1, 0);
    check("rd_stall.rdata_const", sm_rdata, 32'hffff_feff);

    // Simultaneous requests held high across two transactions: writes only.
    run_txn("both_1", 1, 1, 32'h0000_0100, 32'h1357_9bdf, 0, 0, '0, 0, 1);
    run_txn("both_2", 1, 1, 32'h0000_0100, 32'h1357_9bdf, 1, 0, '0, 0, 0);

    // Upper address bits drop on the shift.
    run_txn("addr_trunc", 1, 0, 32'hc000_0001, 32'h0bad_f00d, 2, 0, '0, 0, 0);
    check("addr_trunc.avm_address", avm_address, 32'h0000_0004);

    // Timeout on a read with no data, then on a stalled write.
    run_txn("to_read", 0, 1, 32'h0000_0040, '0, 0, 1000, 32'hdead_beef, 0, 0);
    run_txn("to_write", 1, 0, 32'h0000_0044, 32'h2222_3333, 20, 0, '0, 0, 0);

    // Exactly TIMEOUT_CYCLES active cycles still completes normally.
    run_txn("edge_write", 1, 0, 32'h0000_0050, 32'h4444_5555, TO - 1, 0, '0, 0, 0);
    run_txn("edge_read", 0, 1, 32'h0000_0054, '0, 4, TO - 5, 32'h6677_8899, 0, 0);

    // Reset while a read waits for data, then a late readdatavalid.
    sm_read = 1'b1; sm_address = 32'h0000_0060;
    rd_seen = 0;
    for (int i = 0; i < 10 && rd_seen == 0; i++) begin
      @(negedge clk);
      avm_waitrequest = 1'b0;
      if (avm_read) rd_seen = 1;
    end
    check("rst_mid.read_issued", rd_seen, 1);
    @(negedge clk);
    check("rst_mid.in_rd_data", {busy, avm_read}, 2'b10);
    #2 reset = 1'b0;
    sm_read = 1'b0;
    #1;
    check("rst_mid.outputs_zero_async",
          |{sm_confirm, sm_rdata, avm_address, avm_write, avm_read, avm_writedata,
            avm_byteenable, busy, timeout_err, txn_count}, 1'b0);
    mdl_count = '0; mdl_terr = 1'b0; mdl_rdata = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    avm_readdatavalid = 1'b1;
    avm_readdata      = 32'h1234_5678;
    @(negedge clk);
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    @(negedge clk);
    check("rst_mid.late_data_ignored", {sm_confirm, busy, sm_rdata, txn_count}, 66'h0);
    run_txn("after_rst", 0, 1, 32'h0000_0070, '0, 1, 2, 32'ha5a5_5a5a, 0, 0);

    // Soak: alternating writes and reads of all-ones with random stalls and a
    // single flipped readback bit; total stall per transaction 0-10 cycles.
    for (int n = 0; n < 1000; n++) begin
      a  = $urandom;
      nw = $urandom_range(0, 10);
      run_txn("soak_wr", 1, 0, a, 32'hffff_ffff, nw, 0, '0, 0, 0);
      a  = $urandom;
      s  = $urandom_range(0, 10);
      nw = $urandom_range(0, s);
      d  = 32'hffff_ffff ^ (32'h1 << $urandom_range(0, 31));
      run_txn("soak_rd", 0, 1, a, '0, nw, s - nw + 1, d, 0, 0);
    end
    check("soak.final_count", txn_count, 32'd2001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
